// File: rtl/alu_resp_scoreboard.sv
// alu_resp_scoreboard: in-order expected/observed ALU result checker with counters and timeout.
// Define ALU_SB_EQV_CHECK_EN to also store and compare the eqv (A=B) bit.
//
// state  | meaning
// IDLE   | queue empty, idle timer held at load value
// WAIT   | entries pending, timer counts down on cycles without act_valid_i
// TMO    | timeout seen, timeout_err_o held, scoring continues until clear/reset
module alu_resp_scoreboard #(
  parameter int W       = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     exp_valid_i,
  output logic                     exp_ready_o,
  input  logic [W-1:0]             exp_f_i,
  input  logic                     exp_cout_i,
  input  logic                     exp_eqv_i,
  input  logic                     act_valid_i,
  input  logic [W-1:0]             act_f_i,
  input  logic                     act_cout_i,
  input  logic                     act_eqv_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              pass_cnt_o,
  output logic [15:0]              fail_cnt_o,
  output logic                     mismatch_o,
  output logic                     orphan_o,
  output logic                     err_sticky_o,
  output logic [15:0]              first_fail_idx_o,
  output logic                     timeout_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);
  localparam logic [15:0]   IDX_NONE = 16'hFFFF;

`ifdef ALU_SB_EQV_CHECK_EN
  localparam int EW = W + 2;
  logic [EW-1:0] exp_ent, act_ent;
  assign exp_ent = {exp_eqv_i, exp_cout_i, exp_f_i};
  assign act_ent = {act_eqv_i, act_cout_i, act_f_i};
`else
  localparam int EW = W + 1;
  logic [EW-1:0] exp_ent, act_ent;
  logic          unused_eqv;
  assign exp_ent    = {exp_cout_i, exp_f_i};
  assign act_ent    = {act_cout_i, act_f_i};
  assign unused_eqv = exp_eqv_i ^ act_eqv_i;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TMO} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [15:0]   cmp_idx_q, cmp_idx_d, ffi_q, ffi_d;
  logic          mismatch_q, mismatch_d, orphan_q, orphan_d, err_q, err_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic          push, pop, orphan_now, hit, fail_now;

  // Only entries stored before this cycle are visible to the compare, so a
  // same-cycle push into an empty queue does not rescue an act.
  assign exp_ready_o = (level_q != LW'(DEPTH));
  assign push        = exp_valid_i && exp_ready_o;
  assign pop         = act_valid_i && (level_q != '0);
  assign orphan_now  = act_valid_i && (level_q == '0);
  assign hit         = (mem_q[rd_ptr_q] == act_ent);
  assign fail_now    = orphan_now || (pop && !hit);

  always_ff @(posedge clk) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= exp_ent;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    cmp_idx_d  = cmp_idx_q;
    ffi_d      = ffi_q;
    err_d      = err_q;
    mismatch_d = fail_now;
    orphan_d   = orphan_now;
    level_d    = level_q + LW'(push) - LW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (pop && hit && (pass_cnt_q != 16'hFFFF)) pass_cnt_d = pass_cnt_q + 16'd1;
    if (fail_now && (fail_cnt_q != 16'hFFFF))   fail_cnt_d = fail_cnt_q + 16'd1;
    if (act_valid_i && (cmp_idx_q != 16'hFFFF)) cmp_idx_d  = cmp_idx_q + 16'd1;
    if (fail_now) begin
      err_d = 1'b1;
      if (!err_q) ffi_d = cmp_idx_q;
    end
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      cmp_idx_d  = '0;
      ffi_d      = IDX_NONE;
      err_d      = 1'b0;
      mismatch_d = 1'b0;
      orphan_d   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = TMR_LOAD;
        if (push) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (level_d == '0) begin
          state_d = S_IDLE;
          tmr_d   = TMR_LOAD;
        end else if (act_valid_i) begin
          tmr_d = TMR_LOAD;
        end else if (tmr_q <= TW'(1)) begin
          state_d = S_TMO;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_TMO:   tmr_d = TMR_LOAD;
      default: state_d = S_IDLE;
    endcase
    if (clear_i) begin
      state_d = S_IDLE;
      tmr_d   = TMR_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= TMR_LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      cmp_idx_q  <= '0;
      ffi_q      <= IDX_NONE;
      err_q      <= 1'b0;
      mismatch_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      cmp_idx_q  <= cmp_idx_d;
      ffi_q      <= ffi_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      orphan_q   <= orphan_d;
    end
  end

  assign level_o          = level_q;
  assign pass_cnt_o       = pass_cnt_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign mismatch_o       = mismatch_q;
  assign orphan_o         = orphan_q;
  assign err_sticky_o     = err_q;
  assign first_fail_idx_o = ffi_q;
  assign timeout_err_o    = (state_q == S_TMO);

endmodule

// File: tb/tb_alu_resp_scoreboard.sv
// Directed bench for alu_resp_scoreboard: vector table for single compares plus
// hand sequences for reset, queue full/wrap, orphan and timeout behaviour.
module tb_alu_resp_scoreboard;
  localparam int W = 4, DEPTH = 8, TIMEOUT = 16;

  logic         clk = 1'b0, rst_n = 1'b1, clear_i = 1'b0;
  logic         exp_valid_i = 1'b0, exp_cout_i = 1'b0, exp_eqv_i = 1'b0;
  logic         act_valid_i = 1'b0, act_cout_i = 1'b0, act_eqv_i = 1'b0;
  logic [W-1:0] exp_f_i = '0, act_f_i = '0;
  logic         exp_ready_o, mismatch_o, orphan_o, err_sticky_o, timeout_err_o;
  logic [3:0]   level_o;
  logic [15:0]  pass_cnt_o, fail_cnt_o, first_fail_idx_o;

  int n_chk = 0, n_fail = 0;

  alu_resp_scoreboard #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_f_i(exp_f_i),
    .exp_cout_i(exp_cout_i), .exp_eqv_i(exp_eqv_i),
    .act_valid_i(act_valid_i), .act_f_i(act_f_i), .act_cout_i(act_cout_i), .act_eqv_i(act_eqv_i),
    .level_o(level_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .mismatch_o(mismatch_o), .orphan_o(orphan_o), .err_sticky_o(err_sticky_o),
    .first_fail_idx_o(first_fail_idx_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ef; logic ec; logic ee;
    logic [3:0] af; logic ac; logic ae;
    bit ok_base; bit ok_eqv;
  } vec_t;
  vec_t vt[8];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [3:0] f, input logic c, input logic e);
    exp_valid_i = 1'b1; exp_f_i = f; exp_cout_i = c; exp_eqv_i = e;
    step();
    exp_valid_i = 1'b0;
  endtask

  task automatic act(input logic [3:0] f, input logic c, input logic e);
    act_valid_i = 1'b1; act_f_i = f; act_cout_i = c; act_eqv_i = e;
    step();
    act_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_level"},    level_o, 0);
    chk({nm, "_ready"},    exp_ready_o, 1);
    chk({nm, "_pass"},     pass_cnt_o, 0);
    chk({nm, "_fail"},     fail_cnt_o, 0);
    chk({nm, "_mismatch"}, mismatch_o, 0);
    chk({nm, "_orphan"},   orphan_o, 0);
    chk({nm, "_err"},      err_sticky_o, 0);
    chk({nm, "_ffi"},      first_fail_idx_o, 16'hFFFF);
    chk({nm, "_tmo"},      timeout_err_o, 0);
  endtask

  int         m_pass, m_fail;
  logic [15:0] m_ffi;
  bit         ok;

  initial begin
    vt[0] = '{4'h9, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[1] = '{4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[2] = '{4'hF, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{4'hA, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{4'h3, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{4'h7, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[7] = '{4'hC, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0};

    #2 rst_n = 1'b0;
    #20;
    chk_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    step();

    // single push/compare vectors
    m_pass = 0; m_fail = 0; m_ffi = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_SB_EQV_CHECK_EN
      ok = vt[i].ok_eqv;
`else
      ok = vt[i].ok_base;
`endif
      push(vt[i].ef, vt[i].ec, vt[i].ee);
      chk($sformatf("vec%0d_pre_mismatch", i), mismatch_o, 0);
      chk($sformatf("vec%0d_level1", i), level_o, 1);
      act(vt[i].af, vt[i].ac, vt[i].ae);
      if (ok) m_pass++;
      else begin
        if (m_ffi == 16'hFFFF) m_ffi = 16'(i);
        m_fail++;
      end
      chk($sformatf("vec%0d_mismatch", i), mismatch_o, ok ? 0 : 1);
      chk($sformatf("vec%0d_orphan", i), orphan_o, 0);
      chk($sformatf("vec%0d_pass", i), pass_cnt_o, m_pass);
      chk($sformatf("vec%0d_fail", i), fail_cnt_o, m_fail);
      chk($sformatf("vec%0d_level0", i), level_o, 0);
    end
    chk("table_ffi", first_fail_idx_o, m_ffi);
    chk("table_err", err_sticky_o, 1);
    do_clear();
    chk_idle("clear1");

    // two in flight, second mismatches
    push(4'h5, 1'b0, 1'b0);
    push(4'hF, 1'b0, 1'b0);
    chk("s3_level2", level_o, 2);
    act(4'h5, 1'b0, 1'b0);
    chk("s3_pass1", pass_cnt_o, 1);
    chk("s3_mm0", mismatch_o, 0);
    act(4'hE, 1'b0, 1'b0);
    chk("s3_mm1", mismatch_o, 1);
    chk("s3_fail1", fail_cnt_o, 1);
    chk("s3_ffi", first_fail_idx_o, 1);
    chk("s3_err", err_sticky_o, 1);
    step();
    chk("s3_mm_pulse", mismatch_o, 0);
    chk("s3_err_hold", err_sticky_o, 1);
    do_clear();

    // fill, drop while full, pop then simultaneous push+pop with wrap
    for (int i = 0; i < 8; i++) push(4'(i), i[0], 1'b0);
    chk("s4_level8", level_o, 8);
    chk("s4_ready0", exp_ready_o, 0);
    push(4'hF, 1'b1, 1'b0);
    chk("s4_drop_level", level_o, 8);
    act(4'h0, 1'b0, 1'b0);
    chk("s4_level7", level_o, 7);
    chk("s4_ready1", exp_ready_o, 1);
    exp_valid_i = 1'b1; exp_f_i = 4'h8; exp_cout_i = 1'b0;
    act_valid_i = 1'b1; act_f_i = 4'h1; act_cout_i = 1'b1;
    step();
    exp_valid_i = 1'b0; act_valid_i = 1'b0;
    chk("s4_level7b", level_o, 7);
    chk("s4_pass2", pass_cnt_o, 2);
    for (int i = 2; i < 9; i++) act(4'(i), i[0], 1'b0);
    chk("s4_pass9", pass_cnt_o, 9);
    chk("s4_fail0", fail_cnt_o, 0);
    chk("s4_empty", level_o, 0);
    do_clear();

    // orphan with same-cycle push
    exp_valid_i = 1'b1; exp_f_i = 4'h3; exp_cout_i = 1'b0;
    act_valid_i = 1'b1; act_f_i = 4'h3; act_cout_i = 1'b0;
    step();
    exp_valid_i = 1'b0; act_valid_i = 1'b0;
    chk("s5_orphan", orphan_o, 1);
    chk("s5_mm", mismatch_o, 1);
    chk("s5_fail", fail_cnt_o, 1);
    chk("s5_level", level_o, 1);
    chk("s5_ffi", first_fail_idx_o, 0);
    act(4'h3, 1'b0, 1'b0);
    chk("s5_orphan_pulse", orphan_o, 0);
    chk("s5_pass", pass_cnt_o, 1);

    // async reset mid-stream
    push(4'h1, 1'b0, 1'b0);
    push(4'h2, 1'b0, 1'b0);
    push(4'h3, 1'b0, 1'b0);
    chk("s1_level3", level_o, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("s1_rst");
    @(negedge clk) rst_n = 1'b1;
    step();
    act(4'h1, 1'b0, 1'b0);
    chk("s1_orphan", orphan_o, 1);
    chk("s1_fail", fail_cnt_o, 1);
    chk("s1_pass", pass_cnt_o, 0);
    do_clear();

    // timeout: act restarts the idle timer; TIMEOUT idle cycles trip it
    push(4'h1, 1'b0, 1'b0);
    push(4'h2, 1'b1, 1'b0);
    repeat (8) step();
    act(4'h1, 1'b0, 1'b0);
    chk("s6_pass1", pass_cnt_o, 1);
    chk("s6_tmo_early", timeout_err_o, 0);
    repeat (TIMEOUT - 1) step();
    chk("s6_tmo_n1", timeout_err_o, 0);
    step();
    chk("s6_tmo", timeout_err_o, 1);
    act(4'h2, 1'b1, 1'b0);
    chk("s6_pass2", pass_cnt_o, 2);
    chk("s6_level0", level_o, 0);
    step();
    chk("s6_tmo_hold", timeout_err_o, 1);
    do_clear();
    chk_idle("s6_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
